// File: rtl/slice_controller.sv
// slice_controller: sequences a measure-and-cut job that divides a measured length
// into slice_num equal pieces.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           job request, accepted in idle when slice_num != 0
//   pause           pause/resume toggle (rising edge)
//   abort           cancel the job at once, no finish pulse
//   slice_num       number of pieces (latched at start)
//   valid/distance  distance sample strobe and value
//   trigger_suc     sensor has accepted the trigger request
//   trigger         sensor trigger request
//   move/back       motor enable and reverse direction
//   cut_end/cut     cutter done and cutter request
//   finish          one-cycle job-complete pulse
//   busy            job active
//   retry           one-cycle echo-timeout pulse
//
// Optional feature: define SLICE_TIMEOUT_EN to enable the echo-wait timeout
// (TIMEOUT_CYC cycles) in the measuring states. Without it those states wait
// indefinitely and retry stays 0.
module slice_controller #(
  parameter int unsigned DIS_W       = 17,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] slice_num,
  input  logic             valid,
  input  logic [DIS_W-1:0] distance,
  input  logic             trigger_suc,
  output logic             trigger,
  output logic             move,
  output logic             back,
  input  logic             cut_end,
  output logic             cut,
  output logic             finish,
  output logic             busy,
  output logic             retry
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StInitTri = 4'd1;
  localparam logic [3:0] StInitMea = 4'd2;
  localparam logic [3:0] StDivide  = 4'd3;
  localparam logic [3:0] StTrigger = 4'd4;
  localparam logic [3:0] StMeasure = 4'd5;
  localparam logic [3:0] StCut     = 4'd6;
  localparam logic [3:0] StBackTri = 4'd7;
  localparam logic [3:0] StBack    = 4'd8;
  localparam logic [3:0] StPause   = 4'd9;

  localparam int unsigned DivCntW = $clog2(DIS_W + 1);

  logic [3:0]         state_q, state_d, resume_q, resume_d, div_succ;
  logic [CNT_W-1:0]   num_q, num_d, cnt_q, cnt_d;
  logic [DIS_W-1:0]   length_q, length_d, location_q, location_d, segment_q, segment_d;
  logic [CNT_W-1:0]   div_rem_q, div_rem_d, div_rem_step;
  logic [DIS_W-1:0]   div_quo_q, div_quo_d, div_quo_step;
  logic [DivCntW-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W:0]     div_shift, div_sub;
  logic               div_ge;
  logic               pause_prev_q, pause_edge, pend_q, pend_d, pausable;
  logic [DIS_W-1:0]   loc_minus_seg;
  logic               tmo_hit;
  logic               trigger_q, move_q, back_q, cut_q, finish_q, busy_q, retry_q;
  logic               trigger_d, move_d, back_d, cut_d, finish_d, busy_d, retry_d;

  assign pause_edge = pause & ~pause_prev_q;
  assign pausable   = state_q inside {StInitTri, StInitMea, StTrigger, StMeasure,
                                      StCut, StBackTri, StBack};
  assign loc_minus_seg = (location_q >= segment_q) ? (location_q - segment_q) : '0;
  assign div_succ      = (num_q > CNT_W'(1)) ? StTrigger : StBackTri;

  // One restoring-division step per cycle: dividend bits enter MSB first and the
  // quotient shifts in at the LSB of the same register.
  assign div_shift    = {div_rem_q, div_quo_q[DIS_W-1]};
  assign div_ge       = div_shift >= {1'b0, num_q};
  assign div_sub      = div_shift - {1'b0, num_q};
  assign div_rem_step = div_ge ? div_sub[CNT_W-1:0] : div_shift[CNT_W-1:0];
  assign div_quo_step = {div_quo_q[DIS_W-2:0], div_ge};

`ifdef SLICE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            waiting;

  assign waiting = state_q inside {StInitMea, StMeasure, StBack};
  assign tmo_hit = waiting && !valid && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      tmo_cnt_q <= '0;
    end else if (state_d == StPause || state_q == StPause) begin
      tmo_cnt_q <= tmo_cnt_q;
    end else if (waiting && !valid && state_d == state_q) begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    length_d   = length_q;
    location_d = location_q;
    segment_d  = segment_q;
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_cnt_d  = div_cnt_q;
    pend_d     = pend_q;
    finish_d   = 1'b0;
    retry_d    = 1'b0;

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else if (pause_edge && pausable) begin
      // A pause while waiting for a sample restarts the measurement on resume.
      state_d = StPause;
      case (state_q)
        StInitMea: resume_d = StInitTri;
        StMeasure: resume_d = StTrigger;
        StBack:    resume_d = StBackTri;
        default:   resume_d = state_q;
      endcase
    end else begin
      case (state_q)
        StIdle: begin
          if (start && (slice_num != '0)) begin
            num_d   = slice_num;
            cnt_d   = '0;
            state_d = StInitTri;
          end
        end
        StInitTri: if (trigger_suc) state_d = StInitMea;
        StInitMea: begin
          if (valid) begin
            length_d   = distance;
            location_d = distance;
            div_quo_d  = distance;
            div_rem_d  = '0;
            div_cnt_d  = '0;
            state_d    = StDivide;
          end else if (tmo_hit) begin
            state_d = StInitTri;
            retry_d = 1'b1;
          end
        end
        StDivide: begin
          div_rem_d = div_rem_step;
          div_quo_d = div_quo_step;
          div_cnt_d = div_cnt_q + DivCntW'(1);
          if (pause_edge) pend_d = 1'b1;
          if (div_cnt_q == DivCntW'(DIS_W - 1)) begin
            segment_d = div_quo_step;
            pend_d    = 1'b0;
            if (pause_edge || pend_q) begin
              state_d  = StPause;
              resume_d = div_succ;
            end else begin
              state_d = div_succ;
            end
          end
        end
        StTrigger: if (trigger_suc) state_d = StMeasure;
        StMeasure: begin
          if (valid) begin
            if (distance <= loc_minus_seg) begin
              state_d = StCut;
              cnt_d   = cnt_q + CNT_W'(1);
            end else begin
              state_d = StTrigger;
            end
          end else if (tmo_hit) begin
            state_d = StTrigger;
            retry_d = 1'b1;
          end
        end
        StCut: begin
          if (cut_end) begin
            location_d = loc_minus_seg;
            if (cnt_q == num_q - CNT_W'(1)) begin
              state_d = StBackTri;
              cnt_d   = '0;
            end else begin
              state_d = StTrigger;
            end
          end
        end
        StBackTri: if (trigger_suc) state_d = StBack;
        StBack: begin
          if (valid) begin
            if (distance >= length_q) begin
              state_d  = StIdle;
              finish_d = 1'b1;
            end
          end else if (tmo_hit) begin
            state_d = StBackTri;
            retry_d = 1'b1;
          end
        end
        StPause: if (pause_edge) state_d = resume_q;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change together with it.
  always_comb begin
    trigger_d = state_d inside {StInitTri, StTrigger, StBackTri};
    move_d    = state_d inside {StTrigger, StMeasure, StBackTri, StBack};
    back_d    = state_d inside {StBackTri, StBack};
    cut_d     = state_d == StCut;
    busy_d    = state_d != StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resume_q     <= StIdle;
      num_q        <= '0;
      cnt_q        <= '0;
      length_q     <= '0;
      location_q   <= '0;
      segment_q    <= '0;
      div_rem_q    <= '0;
      div_quo_q    <= '0;
      div_cnt_q    <= '0;
      pend_q       <= 1'b0;
      pause_prev_q <= 1'b0;
      trigger_q    <= 1'b0;
      move_q       <= 1'b0;
      back_q       <= 1'b0;
      cut_q        <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
      retry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      length_q     <= length_d;
      location_q   <= location_d;
      segment_q    <= segment_d;
      div_rem_q    <= div_rem_d;
      div_quo_q    <= div_quo_d;
      div_cnt_q    <= div_cnt_d;
      pend_q       <= pend_d;
      pause_prev_q <= pause;
      trigger_q    <= trigger_d;
      move_q       <= move_d;
      back_q       <= back_d;
      cut_q        <= cut_d;
      finish_q     <= finish_d;
      busy_q       <= busy_d;
      retry_q      <= retry_d;
    end
  end

  assign trigger = trigger_q;
  assign move    = move_q;
  assign back    = back_q;
  assign cut     = cut_q;
  assign finish  = finish_q;
  assign busy    = busy_q;
  assign retry   = retry_q;

endmodule

// File: tb/tb_slice_controller.sv
module tb_slice_controller;

  localparam int unsigned DIS_W = 17;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] slice_num = '0;
  logic             valid = 1'b0;
  logic [DIS_W-1:0] distance = '0;
  logic             trigger_suc = 1'b0;
  logic             cut_end = 1'b0;
  logic             trigger, move, back, cut, finish, busy, retry;

  always #5 clk = ~clk;

  slice_controller #(
    .DIS_W      (DIS_W),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(3000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .slice_num  (slice_num),
    .valid      (valid),
    .distance   (distance),
    .trigger_suc(trigger_suc),
    .trigger    (trigger),
    .move       (move),
    .back       (back),
    .cut_end    (cut_end),
    .cut        (cut),
    .finish     (finish),
    .busy       (busy),
    .retry      (retry)
  );

  int total = 0;
  int bad   = 0;
  bit broken = 1'b0;

  typedef struct packed {
    logic       is_fin;
    logic [7:0] idx;
  } ev_t;

  ev_t exp_q[$];

  function automatic void check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endfunction

  function automatic void pop_expect(input logic is_fin, input int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got event %0d required none", is_fin ? "finish" : "cut", idx);
      return;
    end
    e = exp_q.pop_front();
    check(is_fin ? "finish_event" : "cut_event", {is_fin, 8'(idx)}, {e.is_fin, e.idx});
  endfunction

  // Monitor: every cut rising edge and finish pulse must match the next expectation.
  logic cut_prev = 1'b0;
  logic fin_prev = 1'b0;
  int   mon_cuts = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cut && !cut_prev) pop_expect(1'b0, mon_cuts + 1);
      if (finish) begin
        if (fin_prev) check("finish_one_cycle", fin_prev, 0);
        else pop_expect(1'b1, 0);
      end
    end
    mon_cuts <= busy ? mon_cuts + ((cut && !cut_prev) ? 1 : 0) : 0;
    cut_prev <= cut;
    fin_prev <= finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return trigger;
      1:       return cut;
      default: return finish;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input string name);
    if (broken) return;
    for (int i = 0; i < 300; i++) begin
      if (sig(sel)) begin
        total++;
        return;
      end
      tick();
    end
    total++;
    bad++;
    $display("FAIL %s: got 0 after 300 cycles required 1", name);
    broken = 1'b1;
  endtask

  task automatic send_valid(input int unsigned d);
    repeat ($urandom_range(0, 2)) tick();
    distance = DIS_W'(d);
    valid    = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic ack_trigger(input string name);
    wait_hi(0, name);
    if (broken) return;
    trigger_suc = 1'b1;
    tick();
    trigger_suc = 1'b0;
  endtask

  task automatic start_job(input int unsigned n);
    start     = 1'b1;
    slice_num = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic init_measure(input int unsigned len, input bit chk_lat);
    int lat;
    ack_trigger("init_trigger");
    if (broken) return;
    send_valid(len);
    if (chk_lat) begin
      lat = 0;
      while (!trigger && lat < 100) begin
        tick();
        lat++;
      end
      check("divide_latency", lat, DIS_W);
    end
  endtask

  task automatic cut_phase(input int unsigned n, input int unsigned len, input bit exact);
    int unsigned seg, loc, tgt, d;
    seg = len / n;
    loc = len;
    for (int k = 1; k < int'(n); k++) begin
      if (broken) return;
      tgt = loc - seg;
      if (!exact) begin
        repeat ($urandom_range(0, 2)) begin
          ack_trigger("retrigger");
          if (broken) return;
          d = tgt + 1 + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 40));
          send_valid(d);
        end
      end
      ack_trigger("cut_trigger");
      if (broken) return;
      exp_q.push_back(ev_t'{is_fin: 1'b0, idx: 8'(k)});
      d = exact ? tgt : tgt - $urandom_range(0, (tgt < 3) ? tgt : 3);
      send_valid(d);
      wait_hi(1, "cut_raise");
      if (broken) return;
      repeat ($urandom_range(0, 3)) tick();
      cut_end = 1'b1;
      tick();
      cut_end = 1'b0;
      loc = loc - seg;
    end
  endtask

  task automatic back_phase(input int unsigned len, input bit exact);
    ack_trigger("back_trigger");
    if (broken) return;
    check("back_direction", {move, back}, 2'b11);
    if (!exact) repeat ($urandom_range(0, 2)) send_valid($urandom_range(0, len - 1));
    exp_q.push_back(ev_t'{is_fin: 1'b1, idx: 8'd0});
    send_valid(exact ? len : len + $urandom_range(0, 500));
    wait_hi(2, "finish_raise");
    if (broken) return;
    tick();
    check("idle_after_finish", {finish, busy, trigger, move, back, cut}, 0);
  endtask

  task automatic end_job();
    if (broken) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      exp_q.delete();
      broken = 1'b0;
    end
    tick();
  endtask

  initial begin
    int unsigned n, len;

    repeat (3) tick();
    check("reset_outputs", {trigger, move, back, cut, finish, busy, retry}, 0);
    rst = 1'b0;
    tick();

    start_job(0);
    tick();
    check("start_zero_ignored", {busy, trigger}, 0);

    // Three pieces of 300: cuts at exactly 200 and 100, return at exactly 300.
    start_job(3);
    check("busy_after_start", {busy, trigger}, 2'b11);
    init_measure(300, 1'b1);
    cut_phase(3, 300, 1'b1);
    back_phase(300, 1'b1);
    end_job();

    // Single piece: no cut, straight back after the divide.
    start_job(1);
    init_measure(500, 1'b1);
    cut_phase(1, 500, 1'b1);
    back_phase(500, 1'b1);
    end_job();

    // Pause edge in MEASURE together with a cutting sample; held for 10 cycles.
    start_job(3);
    init_measure(300, 1'b1);
    ack_trigger("pause_trigger");
    if (!broken) begin
      pause    = 1'b1;
      valid    = 1'b1;
      distance = DIS_W'(200);
      tick();
      valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        check("paused_outputs", {busy, trigger, move, back, cut}, 5'b10000);
        tick();
      end
      pause = 1'b0;
      tick();
      check("still_paused", {busy, trigger, move}, 3'b100);
      pause = 1'b1;
      tick();
      check("resume_trigger", {busy, trigger, move, back}, 4'b1110);
      pause = 1'b0;
    end
    cut_phase(3, 300, 1'b0);
    back_phase(300, 1'b0);
    end_job();

    // Pause edge during DIVIDE is held until the divide completes.
    start_job(2);
    init_measure(1000, 1'b0);
    if (!broken) begin
      repeat (3) tick();
      pause = 1'b1;
      tick();
      pause = 1'b0;
      repeat (DIS_W + 3) tick();
      check("divide_pause_held", {busy, trigger, move, back, cut}, 5'b10000);
      pause = 1'b1;
      tick();
      pause = 1'b0;
      check("divide_pause_resume", {trigger, move, back}, 3'b110);
    end
    cut_phase(2, 1000, 1'b0);
    back_phase(1000, 1'b0);
    end_job();

    // Abort while the cutter is requested.
    start_job(4);
    init_measure(4000, 1'b1);
    ack_trigger("abort_trigger");
    if (!broken) begin
      exp_q.push_back(ev_t'{is_fin: 1'b0, idx: 8'd1});
      send_valid(3000);
      wait_hi(1, "abort_cut_raise");
    end
    if (!broken) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_outputs", {cut, finish, busy, trigger, move, back}, 0);
    end
    end_job();

    // Reset in the middle of BACK, then a zero-piece start.
    start_job(1);
    init_measure(500, 1'b0);
    ack_trigger("rst_back_trigger");
    if (!broken) begin
      check("in_back", {move, back, busy}, 3'b111);
      rst = 1'b1;
      tick();
      check("rst_outputs", {trigger, move, back, cut, finish, busy, retry}, 0);
      rst = 1'b0;
      tick();
      start_job(0);
      repeat (2) tick();
      check("start_zero_after_rst", {busy, trigger}, 0);
    end
    end_job();

    // Random jobs against the arithmetic model.
    for (int j = 0; j < 12; j++) begin
      n   = (j == 11) ? 31 : $urandom_range(1, 8);
      len = $urandom_range(n, 100000);
      start_job(n);
      init_measure(len, 1'b1);
      cut_phase(n, len, 1'b0);
      back_phase(len, 1'b0);
      end_job();
    end

    repeat (3) tick();
    check("leftover_events", exp_q.size(), 0);
    check("retry_idle", retry, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
